a1_485_bus_ctrl: RTL

A1_485_BUS_CTRL -- requirements
Module: a1_485_bus_ctrl

---
 rtl/a1_485_pkg.sv | 26 ++
 rtl/a1_485_guard_cnt.sv | 34 +++
 rtl/a1_485_bus_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/a1_485_pkg.sv
// Shared types and defaults for the RS-485 half-duplex bus controller.
package a1_485_pkg;

  typedef enum logic [2:0] {
    StRx    = 3'd0,
    StPre   = 3'd1,
    StTx    = 3'd2,
    StDrain = 3'd3,
    StPost  = 3'd4
  } bus_state_e;

  localparam int unsigned GuardW = 16;
  localparam int unsigned WdW    = 24;

  localparam int unsigned    PreGuardDefault  = 96;
  localparam int unsigned    PostGuardDefault = 960;
  localparam logic [WdW-1:0] TxTimeoutDefault = 24'd9_600_000;

  // Down-counter load value so a guard of N cycles spans N states; 0 behaves like 1.
  function automatic logic [GuardW-1:0] guard_load_val(input int unsigned cycles);
    if (cycles == 0) return '0;
    if (cycles - 1 > (2 ** GuardW) - 1) return '1;
    return GuardW'(cycles - 1);
  endfunction

endpackage

// File: rtl/a1_485_guard_cnt.sv
// Loadable saturating down-counter used to time the PRE and POST bus guards.
module a1_485_guard_cnt
  import a1_485_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [GuardW-1:0] load_val_i,
  output logic              zero_o
);

  logic [GuardW-1:0] cnt_q;
  logic [GuardW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/a1_485_bus_ctrl.sv
// RS-485 driver/receiver arbiter: guards DE around transmissions, grants one requester at a time.
module a1_485_bus_ctrl
  import a1_485_pkg::*;
#(
  parameter int unsigned    PRE_GUARD  = PreGuardDefault,
  parameter int unsigned    POST_GUARD = PostGuardDefault,
  parameter logic [WdW-1:0] TX_TIMEOUT = TxTimeoutDefault
) (
  input  logic       clk_96M,
  input  logic       rst,
  input  logic       rx_frame_done,
  input  logic       req_resp,
  input  logic       req_data,
  input  logic       done_resp,
  input  logic       done_data,
  input  logic       tx_busy,
  output logic       f_re,
  output logic       f_de,
  output logic       gnt_resp,
  output logic       gnt_data,
  output logic       timeout_err,
  output logic [2:0] bus_state
);

  localparam logic [GuardW-1:0] PreLoad  = guard_load_val(PRE_GUARD);
  localparam logic [GuardW-1:0] PostLoad = guard_load_val(POST_GUARD);
  localparam logic [WdW-1:0]    WdLast   = (TX_TIMEOUT == '0) ? '0 : TX_TIMEOUT - 1'b1;

  bus_state_e        state_q, state_d;
  logic              win_data_q, win_data_d;  // latched winner: 1 = read-data requester
  logic              arm_q;
  logic [WdW-1:0]    wd_q;
  logic              f_re_q, f_de_q, gnt_resp_q, gnt_data_q, timeout_err_q;
  logic              timeout_d;
  logic              grant_done;
  logic              wd_hit;
  logic              cur_active, nxt_active;
  logic              guard_load;
  logic [GuardW-1:0] guard_val;
  logic              guard_zero;

  a1_485_guard_cnt u_guard_cnt (
    .clk_i      (clk_96M),
    .rst_i      (rst),
    .load_i     (guard_load),
    .load_val_i (guard_val),
    .zero_o     (guard_zero)
  );

  assign cur_active = (state_q == StPre) || (state_q == StTx) || (state_q == StDrain);
  assign nxt_active = (state_d == StPre) || (state_d == StTx) || (state_d == StDrain);

  always_comb begin
    state_d    = state_q;
    win_data_d = win_data_q;
    timeout_d  = 1'b0;
    grant_done = (state_q == StTx) && (win_data_q ? done_data : done_resp);
    wd_hit     = cur_active && (wd_q >= WdLast);

    unique case (state_q)
      StRx: begin
        // A frame-done pulse arms and launches in the same cycle when a request is already up.
        if ((arm_q || rx_frame_done) && (req_resp || req_data)) begin
          state_d    = StPre;
          win_data_d = !req_resp;
        end
      end
      StPre: begin
        if (guard_zero) begin
          state_d = (win_data_q ? req_data : req_resp) ? StTx : StPost;
        end
      end
      StTx: begin
        if (grant_done) state_d = StDrain;
      end
      StDrain: begin
        if (!tx_busy) state_d = StPost;
      end
      StPost: begin
        if (guard_zero) state_d = StRx;
      end
      default: state_d = StRx;
    endcase

    // Granted done beats a coincident watchdog expiry.
    if (wd_hit && !grant_done) begin
      state_d   = StRx;
      timeout_d = 1'b1;
    end

    guard_load = (state_d != state_q) && ((state_d == StPre) || (state_d == StPost));
    guard_val  = (state_d == StPre) ? PreLoad : PostLoad;
  end

  always_ff @(posedge clk_96M) begin
    if (rst) begin
      state_q       <= StRx;
      win_data_q    <= 1'b0;
      arm_q         <= 1'b0;
      wd_q          <= '0;
      f_re_q        <= 1'b0;
      f_de_q        <= 1'b0;
      gnt_resp_q    <= 1'b0;
      gnt_data_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_data_q <= win_data_d;

      if (((state_d == StPre) && (state_q == StRx)) || timeout_d) begin
        arm_q <= 1'b0;
      end else if ((state_q == StRx) && rx_frame_done) begin
        arm_q <= 1'b1;
      end

      if (cur_active && nxt_active) begin
        if (wd_q != '1) wd_q <= wd_q + 1'b1;
      end else begin
        wd_q <= '0;
      end

      f_re_q        <= (state_d != StRx);
      f_de_q        <= (state_d != StRx);
      gnt_resp_q    <= (state_d == StTx) && !win_data_d;
      gnt_data_q    <= (state_d == StTx) && win_data_d;
      timeout_err_q <= timeout_d;
    end
  end

  assign f_re        = f_re_q;
  assign f_de        = f_de_q;
  assign gnt_resp    = gnt_resp_q;
  assign gnt_data    = gnt_data_q;
  assign timeout_err = timeout_err_q;
  assign bus_state   = state_q;

endmodule
